bp_be_dual_issue_scheduler: RTL and testbench

//  Issue-pairing controller between the dual-slot FE issue queue and the BE dispatch stage.
//  - Each cycle, examines the two head pre-issue packets and decides to issue both slots, slot 1 only, or none.
//  - Drives the queue yumi handshakes and registered issue-valid strobes.
//  - Serialises CSR/fence ops and enforces one-mem-port and one-long-unit limits plus intra-pair RAW/WAW.

---
 rtl/bp_be_pkg.sv | 65 ++++++
 rtl/bp_be_pair_check.sv | 68 ++++++
 rtl/bp_be_dual_issue_scheduler.sv | 177 +++++++++++++++++
 tb/tb_bp_be_dual_issue_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module  : bp_be_pkg
// Brief   : Shared types for the BE dual-issue scheduler: processor config
//           selector, issue packet, dispatch FSM states and pair-hazard bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_be_pkg;

  // Processor configuration selector
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int reg_addr_width_gp = 5;

  // Register-address width implied by a processor configuration
  function automatic int bp_reg_addr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return reg_addr_width_gp;
      default:          return reg_addr_width_gp;
    endcase
  endfunction

  // Pre-issue packet as presented at the head of the FE issue queue
  typedef struct packed {
    logic                         csr_v;
    logic                         fence_v;
    logic                         mem_v;
    logic                         long_v;
    logic                         irs1_v;
    logic                         irs2_v;
    logic                         frs1_v;
    logic                         frs2_v;
    logic                         frs3_v;
    logic [reg_addr_width_gp-1:0] rs1_addr;
    logic [reg_addr_width_gp-1:0] rs2_addr;
    logic [reg_addr_width_gp-1:0] rs3_addr;
  } bp_be_issue_pkt_s;

  localparam int issue_pkt_width_lp = $bits(bp_be_issue_pkt_s);

  // Dispatch controller states
  typedef enum logic [1:0] {
    e_dis_reset  = 2'd0,
    e_dis_run    = 2'd1,
    e_dis_serial = 2'd2
  } bp_be_dis_state_e;

  // Individual reasons a head pair cannot issue together (also used by trace)
  typedef struct packed {
    logic serial;
    logic mem;
    logic long_op;
    logic raw_int;
    logic raw_fp;
    logic waw;
  } bp_be_pair_block_s;

  localparam int pair_block_width_lp = $bits(bp_be_pair_block_s);

endpackage

`default_nettype wire

// File: rtl/bp_be_pair_check.sv
// ============================================================================
// Module  : bp_be_pair_check
// Brief   : Combinational pairing-hazard detector for the two head issue
//           packets; reports every reason slot 2 may not issue with slot 1,
//           plus the slot-1 attributes the dispatch controller needs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_pair_check
  import bp_be_pkg::*;
(
  input  logic [issue_pkt_width_lp-1:0]  pkt1_i,
  input  logic [issue_pkt_width_lp-1:0]  pkt2_i,
  input  logic [reg_addr_width_gp-1:0]   rd1_addr_i,
  input  logic [reg_addr_width_gp-1:0]   rd2_addr_i,
  input  logic                           irf_w1_i,
  input  logic                           frf_w1_i,
  input  logic                           irf_w2_i,
  input  logic                           frf_w2_i,
  output logic [pair_block_width_lp-1:0] block_o,
  output logic                           pkt1_serial_o,
  output logic                           pkt1_mem_o,
  output logic                           pkt1_long_o
);

  bp_be_issue_pkt_s  w_pkt1;
  bp_be_issue_pkt_s  w_pkt2;
  bp_be_pair_block_s w_block;
  logic              w_rd1_nz;
  logic              w_unused_pkt1_srcs;

  assign w_pkt1 = bp_be_issue_pkt_s'(pkt1_i);
  assign w_pkt2 = bp_be_issue_pkt_s'(pkt2_i);

  // Slot-1 source fields only matter against older, already-issued ops
  assign w_unused_pkt1_srcs = ^{w_pkt1.irs1_v, w_pkt1.irs2_v, w_pkt1.frs1_v,
                                w_pkt1.frs2_v, w_pkt1.frs3_v, w_pkt1.rs1_addr,
                                w_pkt1.rs2_addr, w_pkt1.rs3_addr};

  assign w_rd1_nz = (rd1_addr_i != '0);

  // Collect each pairing hazard separately so trace can show the cause
  always_comb begin
    w_block = '0;
    w_block.serial  = w_pkt1.csr_v | w_pkt1.fence_v | w_pkt2.csr_v | w_pkt2.fence_v;
    w_block.mem     = w_pkt1.mem_v & w_pkt2.mem_v;
    w_block.long_op = w_pkt1.long_v & w_pkt2.long_v;
    // x0 is hard-wired zero, so an int write to it never creates a dependency
    w_block.raw_int = irf_w1_i & w_rd1_nz
                    & ((w_pkt2.irs1_v & (w_pkt2.rs1_addr == rd1_addr_i))
                     | (w_pkt2.irs2_v & (w_pkt2.rs2_addr == rd1_addr_i)));
    w_block.raw_fp  = frf_w1_i
                    & ((w_pkt2.frs1_v & (w_pkt2.rs1_addr == rd1_addr_i))
                     | (w_pkt2.frs2_v & (w_pkt2.rs2_addr == rd1_addr_i))
                     | (w_pkt2.frs3_v & (w_pkt2.rs3_addr == rd1_addr_i)));
    w_block.waw     = (rd1_addr_i == rd2_addr_i)
                    & ((irf_w1_i & irf_w2_i & w_rd1_nz) | (frf_w1_i & frf_w2_i));
  end

  assign block_o       = w_block;
  assign pkt1_serial_o = w_pkt1.csr_v | w_pkt1.fence_v;
  assign pkt1_mem_o    = w_pkt1.mem_v;
  assign pkt1_long_o   = w_pkt1.long_v;

endmodule

`default_nettype wire

// File: rtl/bp_be_dual_issue_scheduler.sv
// ============================================================================
// Module  : bp_be_dual_issue_scheduler
// Brief   : Issue-pairing controller between the dual-slot FE issue queue and
//           BE dispatch. Chooses pair / slot-1-only / none each cycle, drives
//           the queue yumi handshakes and registered issue-valid strobes, and
//           serialises CSR/fence ops behind a drain window.
//           Optional perf counters: define BP_BE_DUAL_ISSUE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_dual_issue_scheduler
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int         drain_cycles_p = 4,
  parameter int         cnt_width_p    = 32
)(
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      clr_i,
  input  logic [issue_pkt_width_lp-1:0]             pkt1_i,
  input  logic [issue_pkt_width_lp-1:0]             pkt2_i,
  input  logic                                      v1_i,
  input  logic                                      v2_i,
  input  logic [bp_reg_addr_width(bp_params_p)-1:0] rd1_addr_i,
  input  logic [bp_reg_addr_width(bp_params_p)-1:0] rd2_addr_i,
  input  logic                                      irf_w1_i,
  input  logic                                      frf_w1_i,
  input  logic                                      irf_w2_i,
  input  logic                                      frf_w2_i,
  input  logic                                      dispatch_ready_i,
  input  logic                                      mem_ready_i,
  input  logic                                      long_busy_i,
  input  logic                                      pipe_empty_i,
  output logic                                      yumi1_o,
  output logic                                      yumi2_o,
  output logic                                      issue_v1_o,
  output logic                                      issue_v2_o,
  output logic                                      serial_o,
  output logic [cnt_width_p-1:0]                    pair_cnt_o,
  output logic [cnt_width_p-1:0]                    single_cnt_o
);

  localparam int drain_width_lp = (drain_cycles_p < 1) ? 1 : $clog2(drain_cycles_p + 1);
  localparam logic [drain_width_lp-1:0] c_drain_init = drain_width_lp'(drain_cycles_p);

  bp_be_dis_state_e            r_state;
  bp_be_dis_state_e            w_state_n;
  logic [drain_width_lp-1:0]   r_drain_cnt;
  logic [drain_width_lp-1:0]   w_drain_cnt_n;
  logic                        r_issue_v1;
  logic                        r_issue_v2;

  logic [pair_block_width_lp-1:0] w_block;
  logic                           w_pkt1_serial;
  logic                           w_pkt1_mem;
  logic                           w_pkt1_long;
  logic                           w_ok1;
  logic                           w_ok2;

  bp_be_pair_check u_pair_check (
    .pkt1_i        (pkt1_i),
    .pkt2_i        (pkt2_i),
    .rd1_addr_i    (rd1_addr_i),
    .rd2_addr_i    (rd2_addr_i),
    .irf_w1_i      (irf_w1_i),
    .frf_w1_i      (frf_w1_i),
    .irf_w2_i      (irf_w2_i),
    .frf_w2_i      (frf_w2_i),
    .block_o       (w_block),
    .pkt1_serial_o (w_pkt1_serial),
    .pkt1_mem_o    (w_pkt1_mem),
    .pkt1_long_o   (w_pkt1_long)
  );

  // Slot 2 only ever goes together with slot 1, so ok2 is built on ok1
  assign w_ok1 = v1_i & dispatch_ready_i & ~clr_i & (r_state == e_dis_run)
               & (~w_pkt1_mem | mem_ready_i)
               & (~w_pkt1_long | ~long_busy_i);
  assign w_ok2 = w_ok1 & v2_i & ~(|w_block);

  assign yumi1_o  = w_ok1;
  assign yumi2_o  = w_ok2;
  assign serial_o = (r_state == e_dis_serial);

  // Dispatch state and drain counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_dis_reset;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_drain_cnt <= w_drain_cnt_n;
    end
  end

  // Next-state logic; a flush overrides everything and reopens issue
  always_comb begin
    w_state_n     = r_state;
    w_drain_cnt_n = r_drain_cnt;
    case (r_state)
      e_dis_reset: begin
        w_state_n = e_dis_run;
      end
      e_dis_run: begin
        if (yumi1_o & w_pkt1_serial) begin
          w_state_n     = e_dis_serial;
          w_drain_cnt_n = c_drain_init;
        end
      end
      e_dis_serial: begin
        if (r_drain_cnt != '0) begin
          w_drain_cnt_n = r_drain_cnt - 1'b1;
        end
        // Leave once the window has elapsed and nothing is left in flight
        if ((w_drain_cnt_n == '0) & pipe_empty_i) begin
          w_state_n = e_dis_run;
        end
      end
      default: begin
        w_state_n = e_dis_reset;
      end
    endcase
    if (clr_i) begin
      w_state_n     = e_dis_run;
      w_drain_cnt_n = '0;
    end
  end

  // Issue strobes line up with the queue's own issue register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_issue_v1 <= 1'b0;
      r_issue_v2 <= 1'b0;
    end else begin
      r_issue_v1 <= yumi1_o & ~clr_i;
      r_issue_v2 <= yumi2_o & ~clr_i;
    end
  end

  assign issue_v1_o = r_issue_v1;
  assign issue_v2_o = r_issue_v2;

`ifdef BP_BE_DUAL_ISSUE_STATS_EN
  if (1) begin : g_stats
    logic [cnt_width_p-1:0] r_pair_cnt;
    logic [cnt_width_p-1:0] r_single_cnt;

    // Saturating pair/single issue counters; flushes do not clear them
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_pair_cnt   <= '0;
        r_single_cnt <= '0;
      end else begin
        if (yumi2_o && (r_pair_cnt != '1)) begin
          r_pair_cnt <= r_pair_cnt + 1'b1;
        end
        if (yumi1_o && !yumi2_o && (r_single_cnt != '1)) begin
          r_single_cnt <= r_single_cnt + 1'b1;
        end
      end
    end

    assign pair_cnt_o   = r_pair_cnt;
    assign single_cnt_o = r_single_cnt;
  end
`else
  if (1) begin : g_no_stats
    assign pair_cnt_o   = '0;
    assign single_cnt_o = '0;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_be_dual_issue_scheduler.sv
// ============================================================================
// Module  : tb_bp_be_dual_issue_scheduler
// Brief   : Randomised self-checking bench for bp_be_dual_issue_scheduler.
//           Expected responses come from an abstract reference model and are
//           queued; a separate monitor compares them against the DUT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_dual_issue_scheduler;
  import bp_be_pkg::*;

  localparam int DRAIN   = 4;
  localparam int CW      = 32;
  localparam int N_ITERS = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset_n;
  logic                          clr;
  logic [issue_pkt_width_lp-1:0] pkt1_v, pkt2_v;
  logic                          v1, v2;
  logic [4:0]                    rd1, rd2;
  logic                          iw1, fw1, iw2, fw2;
  logic                          dispatch_ready, mem_ready, long_busy, pipe_empty;
  logic                          yumi1, yumi2, issue_v1, issue_v2, serial;
  logic [CW-1:0]                 pair_cnt, single_cnt;

  bp_be_dual_issue_scheduler #(
    .bp_params_p    (e_bp_default_cfg),
    .drain_cycles_p (DRAIN),
    .cnt_width_p    (CW)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .clr_i            (clr),
    .pkt1_i           (pkt1_v),
    .pkt2_i           (pkt2_v),
    .v1_i             (v1),
    .v2_i             (v2),
    .rd1_addr_i       (rd1),
    .rd2_addr_i       (rd2),
    .irf_w1_i         (iw1),
    .frf_w1_i         (fw1),
    .irf_w2_i         (iw2),
    .frf_w2_i         (fw2),
    .dispatch_ready_i (dispatch_ready),
    .mem_ready_i      (mem_ready),
    .long_busy_i      (long_busy),
    .pipe_empty_i     (pipe_empty),
    .yumi1_o          (yumi1),
    .yumi2_o          (yumi2),
    .issue_v1_o       (issue_v1),
    .issue_v2_o       (issue_v2),
    .serial_o         (serial),
    .pair_cnt_o       (pair_cnt),
    .single_cnt_o     (single_cnt)
  );

  typedef struct {
    logic          y1, y2, ser, iv1, iv2;
    logic [CW-1:0] pc, sc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0 = reset, 1 = running, 2 = serialising
  int          m_mode;
  int          m_left;
  logic        m_prev_y1, m_prev_y2;
  longint      m_pairs, m_singles;
  bp_be_issue_pkt_s p1, p2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One random instruction of a random class
  task automatic gen_slot(output bp_be_issue_pkt_s p, output logic iw, output logic fw);
    int kind;
    p    = '0;
    iw   = 1'b0;
    fw   = 1'b0;
    kind = $urandom_range(0, 11);
    p.rs1_addr = 5'($urandom_range(0, 3));
    p.rs2_addr = 5'($urandom_range(0, 3));
    p.rs3_addr = 5'($urandom_range(0, 3));
    case (kind)
      0, 1, 2, 3: begin p.irs1_v = 1'b1; p.irs2_v = 1'($urandom_range(0, 1)); iw = 1'b1; end
      4:          begin p.mem_v = 1'b1; p.irs1_v = 1'b1; iw = 1'b1; end
      5:          begin p.mem_v = 1'b1; p.irs1_v = 1'b1; p.irs2_v = 1'b1; end
      6:          begin p.mem_v = 1'b1; p.irs1_v = 1'b1; fw = 1'b1; end
      7:          begin p.long_v = 1'b1; p.irs1_v = 1'b1; p.irs2_v = 1'b1; iw = 1'b1; end
      8, 9:       begin p.frs1_v = 1'b1; p.frs2_v = 1'b1; p.frs3_v = 1'($urandom_range(0, 1)); fw = 1'b1; end
      10:         begin p.csr_v = 1'b1; p.irs1_v = 1'b1; iw = 1'($urandom_range(0, 1)); end
      default:    begin p.fence_v = 1'b1; end
    endcase
  endtask

  function automatic logic is_serial(input bp_be_issue_pkt_s p);
    return p.csr_v || p.fence_v;
  endfunction

  // May these two instructions leave the queue in the same cycle?
  function automatic logic may_pair();
    logic [4:0] int_srcs[$];
    logic [4:0] fp_srcs[$];
    if (is_serial(p1) || is_serial(p2)) return 1'b0;
    if (p1.mem_v && p2.mem_v)           return 1'b0;
    if (p1.long_v && p2.long_v)         return 1'b0;
    if (p2.irs1_v) int_srcs.push_back(p2.rs1_addr);
    if (p2.irs2_v) int_srcs.push_back(p2.rs2_addr);
    if (p2.frs1_v) fp_srcs.push_back(p2.rs1_addr);
    if (p2.frs2_v) fp_srcs.push_back(p2.rs2_addr);
    if (p2.frs3_v) fp_srcs.push_back(p2.rs3_addr);
    if (iw1 && rd1 != 0)
      foreach (int_srcs[i]) if (int_srcs[i] == rd1) return 1'b0;
    if (fw1)
      foreach (fp_srcs[i]) if (fp_srcs[i] == rd1) return 1'b0;
    if (rd1 == rd2 && iw1 && iw2 && rd1 != 0) return 1'b0;
    if (rd1 == rd2 && fw1 && fw2)             return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic slot1_may_go();
    if (m_mode != 1 || !v1 || !dispatch_ready || clr) return 1'b0;
    if (p1.mem_v && !mem_ready)                       return 1'b0;
    if (p1.long_v && long_busy)                       return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    m_left    = 0;
    m_prev_y1 = 1'b0;
    m_prev_y2 = 1'b0;
    m_pairs   = 0;
    m_singles = 0;
  endtask

  // Drive one random cycle, queue the expected response, advance the model
  task automatic run_cycle();
    exp_t e;
    logic y1, y2;
    gen_slot(p1, iw1, fw1);
    gen_slot(p2, iw2, fw2);
    pkt1_v         = p1;
    pkt2_v         = p2;
    rd1            = 5'($urandom_range(0, 3));
    rd2            = 5'($urandom_range(0, 3));
    v1             = ($urandom_range(0, 7) != 0);
    v2             = ($urandom_range(0, 3) != 0);
    dispatch_ready = ($urandom_range(0, 7) != 0);
    mem_ready      = ($urandom_range(0, 3) != 0);
    long_busy      = ($urandom_range(0, 3) == 0);
    pipe_empty     = ($urandom_range(0, 3) != 0);
    clr            = ($urandom_range(0, 24) == 0);

    y1 = slot1_may_go();
    y2 = y1 && v2 && may_pair();

    e.y1  = y1;
    e.y2  = y2;
    e.ser = (m_mode == 2);
    e.iv1 = m_prev_y1;
    e.iv2 = m_prev_y2;
`ifdef BP_BE_DUAL_ISSUE_STATS_EN
    e.pc  = CW'(m_pairs);
    e.sc  = CW'(m_singles);
`else
    e.pc  = '0;
    e.sc  = '0;
`endif
    sb.push_back(e);

    m_prev_y1 = y1;
    m_prev_y2 = y2;
    if (y2) m_pairs++;
    else if (y1) m_singles++;

    if (clr) begin
      m_mode = 1;
      m_left = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (y1 && is_serial(p1)) begin
        m_mode = 2;
        m_left = DRAIN;
      end
    end else begin
      if (m_left > 0) m_left--;
      if (m_left == 0 && pipe_empty) m_mode = 1;
    end
  endtask

  // Monitor: compare each queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("yumi1", 64'(yumi1), 64'(e.y1));
        check("yumi2", 64'(yumi2), 64'(e.y2));
        check("slot2_alone", 64'(yumi2 & ~yumi1), 64'(0));
        check("serial", 64'(serial), 64'(e.ser));
        check("issue_v1", 64'(issue_v1), 64'(e.iv1));
        check("issue_v2", 64'(issue_v2), 64'(e.iv2));
        check("pair_cnt", 64'(pair_cnt), 64'(e.pc));
        check("single_cnt", 64'(single_cnt), 64'(e.sc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_yumi1"}, 64'(yumi1), 64'(0));
    check({tag, "_yumi2"}, 64'(yumi2), 64'(0));
    check({tag, "_issue_v1"}, 64'(issue_v1), 64'(0));
    check({tag, "_issue_v2"}, 64'(issue_v2), 64'(0));
    check({tag, "_serial"}, 64'(serial), 64'(0));
    check({tag, "_pair_cnt"}, 64'(pair_cnt), 64'(0));
    check({tag, "_single_cnt"}, 64'(single_cnt), 64'(0));
  endtask

  initial begin
    bit did_mid_reset;
    did_mid_reset  = 1'b0;
    reset_n        = 1'b0;
    clr            = 1'b0;
    pkt1_v         = '0;
    pkt2_v         = '0;
    v1             = 1'b1;
    v2             = 1'b1;
    rd1            = '0;
    rd2            = '0;
    iw1            = 1'b0;
    fw1            = 1'b0;
    iw2            = 1'b0;
    fw2            = 1'b0;
    dispatch_ready = 1'b1;
    mem_ready      = 1'b1;
    long_busy      = 1'b0;
    pipe_empty     = 1'b1;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int it = 0; it < N_ITERS; it++) begin
      // Asynchronous reset while serialising must clear everything at once
      if (!did_mid_reset && it >= N_ITERS / 2 && (m_mode == 2 || it >= N_ITERS - 10)) begin
        did_mid_reset = 1'b1;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
      end
      run_cycle();
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
